dma_io_channel: RTL and testbench
=================================

Name: dma_io_channel

Overview:
- Single-channel DMA engine sitting directly downstream of the IO device buffer.
- Detects the device's GPIO interrupt request and takes the system bus from the CPU via bus_req/bus_gnt.
- Acknowledges the device, reads a programmed number of words out of the device buffer by index, and writes them to consecutive memory addresses.
- Raises a one-cycle completion interrupt to the CPU when the burst finishes.

Parameters:
- DATA_W, 32, data word width on device and memory sides
- DEV_AW, 8, device buffer address width; device index is {chip-select, addr} = DEV_AW+1 bits
- MEM_AW, 16, memory address width
- MAX_LEN, 32, maximum words per burst; equals device buffer depth

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- cfg_load  in  1  one-cycle strobe; latches the three cfg_* values and arms the channel
- cfg_dev_base  in  DEV_AW  first device buffer slot
- cfg_mem_base  in  MEM_AW  first memory word address
- cfg_len  in  6  words to move, 1..MAX_LEN
- dreq  in  1  device interrupt/request (device GPIO line)
- dev_ack  out  1  acknowledge to device
- dev_index  out  DEV_AW+1  {cs, addr} to device
- dev_iowrite  out  1  1 = write into device, 0 = read from device
- dev_rdata  in  DATA_W  device read data
- dev_wdata  out  DATA_W  device write data (optional feature only)
- bus_req  out  1  bus hold request to CPU
- bus_gnt  in  1  bus hold acknowledge from CPU
- mem_addr  out  MEM_AW  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write request
- mem_ready  in  1  memory accepted write this cycle
- busy  out  1  channel owns or requests the bus
- done_irq  out  1  one-cycle pulse at end of burst
- xfer_count  out  6  words completed in current/last burst

Behaviour:
- Reset values:
  - State IDLE, armed=0.
  - All outputs 0, except dev_iowrite=1 (idle = no read drive).
  - xfer_count=0; latched config=0.
- Configuration:
  - cfg_load is accepted only in IDLE or DONE.
  - cfg_len=0 or cfg_len>MAX_LEN is rejected; armed stays 0.
  - cfg_load while busy is ignored.
  - A successful load sets armed=1 and clears xfer_count.
- IDLE: if armed and dreq==1 -> BUS_REQ.
- BUS_REQ:
  - bus_req=1, busy=1.
  - When bus_gnt==1, assert dev_ack=1 and go to RD.
- RD (1 cycle):
  - dev_index={1, dev_ptr}, dev_iowrite=0.
  - Go to CAP.
- CAP (1 cycle):
  - Index still driven; data_reg <= dev_rdata at the end of the cycle.
  - Go to MEM_WR. Device read latency is fixed at 2 cycles.
- MEM_WR:
  - mem_we=1, mem_addr=mem_ptr, mem_wdata=data_reg.
  - All three are held stable until mem_ready==1 is sampled; then go to NEXT.
  - Unbounded wait; there is no timeout.
- NEXT (1 cycle):
  - xfer_count+1, dev_ptr+1, mem_ptr+1.
  - dev_ptr wraps modulo 2^DEV_AW; mem_ptr wraps modulo 2^MEM_AW.
  - If xfer_count+1==len -> DONE.
  - Else if bus_gnt==0 -> BUS_REQ. bus_req stays 1 and dev_ack stays 1; the burst resumes at the current pointers.
  - Else -> RD.
- DONE (1 cycle):
  - done_irq=1; bus_req, dev_ack and busy drop to 0; armed=0.
  - Go to IDLE.
- dev_ack is high from grant until DONE, including during a regrant wait.
- dev_index cs bit is 0 outside RD/CAP (and outside CLR when the optional feature is compiled in).
- dreq falling mid-burst is ignored; the burst runs to len.
- dreq high while not armed: no action.
- bus_gnt dropping during RD/CAP/MEM_WR: the current word is completed; the drop is observed only at NEXT.
- reset asserted in any state: next edge returns to reset values; the partial burst is abandoned and no done_irq is issued.
- cfg_len=MAX_LEN (32) uses the full 6-bit count.

Optional Feature:
- DMA_CLEAR_SRC_EN defined:
  - After CAP, insert state CLR (1 cycle) before MEM_WR.
  - In CLR: dev_index={1, dev_ptr}, dev_iowrite=1, dev_wdata=0, so each consumed device slot is zeroed.
  - Per-word latency becomes 4 cycles + memory wait.
- Undefined:
  - No CLR state; dev_wdata is tied to 0 and the device buffer is left intact.
  - Per-word latency is 3 cycles + memory wait.

Test Plan:
- Basic burst: load dev_base=0, mem_base=0x0100, len=4; dreq=1; bus_gnt 1 cycle after bus_req; mem_ready always 1; device slots hold 0..3 -> mem[0x100..0x103]=0,1,2,3; done_irq exactly one pulse; xfer_count=4; bus_req low after DONE.
- Memory backpressure: len=2; mem_ready low for 3 cycles on word 0 -> mem_we/mem_addr/mem_wdata stable all 3 cycles; exactly 2 writes total.
- Bus revoke: len=5; drop bus_gnt during word 1's MEM_WR, restore 4 cycles later -> word 1 completes; RD is stalled until regrant; dev_ack stays high; 5 writes in order.
- Wrap and max: dev_base=0xFE, mem_base=0xFFFE, len=32 -> device reads 0xFE,0xFF,0x00..; mem_addr wraps 0xFFFF->0x0000; xfer_count=32.
- Config guards: cfg_len=0 then dreq=1 -> no bus_req. cfg_load during a busy burst -> ignored; the burst completes with the original len.
- Reset mid-op: assert reset in MEM_WR of word 2 -> next edge: all outputs at reset values; no done_irq. With DMA_CLEAR_SRC_EN: each read slot is subsequently written with 0, dev_iowrite=1 for one cycle per word.

Source files
------------

// File: rtl/dma_io_channel.sv
// Single-channel DMA: pulls words from the IO device buffer and writes them to memory.
// Optional source clearing (zero each consumed device slot) is enabled by DMA_CLEAR_SRC_EN.
module dma_io_channel #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEV_AW  = 8,
  parameter int unsigned MEM_AW  = 16,
  parameter int unsigned MAX_LEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_load,
  input  logic [DEV_AW-1:0] cfg_dev_base,
  input  logic [MEM_AW-1:0] cfg_mem_base,
  input  logic [5:0]        cfg_len,
  input  logic              dreq,
  output logic              dev_ack,
  output logic [DEV_AW:0]   dev_index,
  output logic              dev_iowrite,
  input  logic [DATA_W-1:0] dev_rdata,
  output logic [DATA_W-1:0] dev_wdata,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done_irq,
  output logic [5:0]        xfer_count
);

  typedef enum logic [2:0] {
    StIdle, StBusReq, StRd, StCap, StClr, StMemWr, StNext, StDone
  } state_e;

  state_e              state_q, state_d;
  logic                armed_q, armed_d;
  logic                ack_q, ack_d;
  logic [DEV_AW-1:0]   dev_ptr_q, dev_ptr_d;
  logic [MEM_AW-1:0]   mem_ptr_q, mem_ptr_d;
  logic [5:0]          len_q, len_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic       load_ok;
  logic [5:0] cnt_inc;

  assign cnt_inc = cnt_q + 6'd1;
  assign load_ok = cfg_load && ((state_q == StIdle) || (state_q == StDone)) &&
                   (cfg_len != 6'd0) && (32'(cfg_len) <= MAX_LEN);

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    ack_d     = ack_q;
    dev_ptr_d = dev_ptr_q;
    mem_ptr_d = mem_ptr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    case (state_q)
      StIdle:   if (armed_q && dreq) state_d = StBusReq;
      StBusReq: begin
        if (bus_gnt) begin
          ack_d   = 1'b1;
          state_d = StRd;
        end
      end
      StRd:     state_d = StCap;
      StCap: begin
        data_d = dev_rdata;
`ifdef DMA_CLEAR_SRC_EN
        state_d = StClr;
`else
        state_d = StMemWr;
`endif
      end
`ifdef DMA_CLEAR_SRC_EN
      StClr:    state_d = StMemWr;
`endif
      StMemWr:  if (mem_ready) state_d = StNext;
      StNext: begin
        cnt_d     = cnt_inc;
        dev_ptr_d = dev_ptr_q + DEV_AW'(1);
        mem_ptr_d = mem_ptr_q + MEM_AW'(1);
        if (cnt_inc == len_q) begin
          ack_d   = 1'b0;
          state_d = StDone;
        end else if (!bus_gnt) begin
          // Bus revoked: keep ack high and resume at the current pointers on regrant
          state_d = StBusReq;
        end else begin
          state_d = StRd;
        end
      end
      StDone: begin
        armed_d = 1'b0;
        state_d = StIdle;
      end
      default:  state_d = StIdle;
    endcase
    // A new load in DONE re-arms even though DONE clears armed
    if (load_ok) begin
      armed_d   = 1'b1;
      cnt_d     = 6'd0;
      dev_ptr_d = cfg_dev_base;
      mem_ptr_d = cfg_mem_base;
      len_d     = cfg_len;
    end
  end

  always_comb begin
    bus_req     = 1'b0;
    busy        = 1'b0;
    dev_iowrite = 1'b1;
    dev_index   = '0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    done_irq    = 1'b0;
    case (state_q)
      StBusReq, StNext: begin
        bus_req = 1'b1;
        busy    = 1'b1;
      end
      StRd, StCap: begin
        bus_req     = 1'b1;
        busy        = 1'b1;
        dev_index   = {1'b1, dev_ptr_q};
        dev_iowrite = 1'b0;
      end
      StClr: begin
        bus_req   = 1'b1;
        busy      = 1'b1;
        dev_index = {1'b1, dev_ptr_q};
      end
      StMemWr: begin
        bus_req   = 1'b1;
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = mem_ptr_q;
        mem_wdata = data_q;
      end
      StDone:   done_irq = 1'b1;
      default:  ;
    endcase
  end

  assign dev_ack    = ack_q;
  assign dev_wdata  = '0;
  assign xfer_count = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      armed_q   <= 1'b0;
      ack_q     <= 1'b0;
      dev_ptr_q <= '0;
      mem_ptr_q <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      ack_q     <= ack_d;
      dev_ptr_q <= dev_ptr_d;
      mem_ptr_q <= mem_ptr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
    end
  end

endmodule

// File: tb/tb_dma_io_channel.sv
// Directed self-checking bench for dma_io_channel with device, bus-arbiter and memory models.
module tb_dma_io_channel;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_load;
  logic [7:0]  cfg_dev_base;
  logic [15:0] cfg_mem_base;
  logic [5:0]  cfg_len;
  logic        dreq;
  logic        dev_ack;
  logic [8:0]  dev_index;
  logic        dev_iowrite;
  logic [31:0] dev_rdata;
  logic [31:0] dev_wdata;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_ready;
  logic        busy;
  logic        done_irq;
  logic [5:0]  xfer_count;

  dma_io_channel dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_load     (cfg_load),
    .cfg_dev_base (cfg_dev_base),
    .cfg_mem_base (cfg_mem_base),
    .cfg_len      (cfg_len),
    .dreq         (dreq),
    .dev_ack      (dev_ack),
    .dev_index    (dev_index),
    .dev_iowrite  (dev_iowrite),
    .dev_rdata    (dev_rdata),
    .dev_wdata    (dev_wdata),
    .bus_req      (bus_req),
    .bus_gnt      (bus_gnt),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_ready    (mem_ready),
    .busy         (busy),
    .done_irq     (done_irq),
    .xfer_count   (xfer_count)
  );

  always #5 clk = ~clk;

`ifdef DMA_CLEAR_SRC_EN
  localparam bit ClearEn = 1'b1;
`else
  localparam bit ClearEn = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [7:0] a);
    return 32'hC0DE_0000 | {24'd0, a};
  endfunction

  // Device buffer: registered index, data valid the cycle after RD (2-cycle read latency)
  logic [31:0] dev_buf [256];
  logic [8:0]  idx_q = '0;
  logic        fill_req = 1'b0;
  always @(posedge clk) begin
    if (fill_req) begin
      for (int a = 0; a < 256; a++) dev_buf[a] <= pat(a[7:0]);
    end else if (dev_index[8] && dev_iowrite) begin
      dev_buf[dev_index[7:0]] <= dev_wdata;
    end
    idx_q <= dev_index;
  end
  assign dev_rdata = dev_buf[idx_q[7:0]];

  // Arbiter grants one cycle after request; memory stalls the first stall_cycles of stall_addr
  logic        gnt_block = 1'b0;
  logic [15:0] stall_addr = 16'hFFFF;
  int          stall_cycles = 0;
  initial begin
    logic req_prev;
    int   run;
    req_prev  = 1'b0;
    run       = 0;
    bus_gnt   = 1'b0;
    mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (mem_we) run++;
      else run = 0;
      mem_ready = !(mem_we && (mem_addr == stall_addr) && (run <= stall_cycles));
      bus_gnt   = req_prev && !gnt_block;
      req_prev  = bus_req;
    end
  end

  logic [15:0] wr_addr [128];
  logic [31:0] wr_data [128];
  int wr_n = 0, stall_n = 0, stable_bad = 0, done_n = 0, breq_n = 0, rd_nogrant = 0, clrw_n = 0;
  logic        prev_we = 1'b0;
  logic [15:0] p_addr = '0;
  logic [31:0] p_data = '0;
  always @(negedge clk) begin
    if (mem_we && mem_ready && wr_n < 128) begin
      wr_addr[wr_n] = mem_addr;
      wr_data[wr_n] = mem_wdata;
      wr_n++;
    end
    if (mem_we && !mem_ready) stall_n++;
    if (mem_we && prev_we && (mem_addr != p_addr || mem_wdata != p_data)) stable_bad++;
    prev_we = mem_we;
    p_addr  = mem_addr;
    p_data  = mem_wdata;
    if (done_irq) done_n++;
    if (bus_req) breq_n++;
    if (dev_index[8] && !bus_gnt) rd_nogrant++;
    if (dev_index[8] && dev_iowrite) clrw_n++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic refill();
    @(negedge clk);
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
  endtask

  task automatic load(input logic [7:0] db, input logic [15:0] mb, input logic [5:0] len);
    @(negedge clk);
    cfg_dev_base = db;
    cfg_mem_base = mb;
    cfg_len      = len;
    cfg_load     = 1'b1;
    @(negedge clk);
    cfg_load     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int  start;
    logic seen;
    start = done_n;
    seen  = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done_irq || done_n != start) seen = 1'b1;
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    tick(3);
  endtask

  task automatic wait_write(input string tag, input logic [15:0] addr, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (mem_we && mem_addr == addr) seen = 1'b1;
    end
    check_eq({tag, "_reach_wr"}, 32'(seen), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_bus_req"}, 32'(bus_req), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_dev_ack"}, 32'(dev_ack), 32'd0);
    check_eq({tag, "_iowrite"}, 32'(dev_iowrite), 32'd1);
    check_eq({tag, "_dev_index"}, 32'(dev_index), 32'd0);
    check_eq({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check_eq({tag, "_done_irq"}, 32'(done_irq), 32'd0);
    check_eq({tag, "_xfer_count"}, 32'(xfer_count), 32'd0);
  endtask

  // Compare n logged writes starting at wb against consecutive addresses and device slots
  task automatic check_burst(input string tag, input int wb, input int n,
                             input logic [15:0] mb, input logic [7:0] db);
    int bad;
    bad = 0;
    check_eq({tag, "_nwrites"}, 32'(wr_n - wb), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (wr_addr[wb+i] !== mb + 16'(i)) bad++;
      if (wr_data[wb+i] !== pat(db + 8'(i))) bad++;
    end
    check_eq({tag, "_order"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int wb, db, cb, sb, bb, rb;
    logic ack_low, req_low;
    reset        = 1'b1;
    cfg_load     = 1'b0;
    cfg_dev_base = '0;
    cfg_mem_base = '0;
    cfg_len      = '0;
    dreq         = 1'b0;
    refill();
    tick(2);
    reset = 1'b0;
    tick(1);
    check_reset_vals("rst");

    // Basic burst
    refill();
    wb = wr_n; db = done_n; cb = clrw_n;
    load(8'h00, 16'h0100, 6'd4);
    dreq = 1'b1;
    wait_done("basic", 200);
    dreq = 1'b0;
    check_burst("basic", wb, 4, 16'h0100, 8'h00);
    check_eq("basic_done_pulses", 32'(done_n - db), 32'd1);
    check_eq("basic_xfer_count", 32'(xfer_count), 32'd4);
    check_eq("basic_bus_req_off", 32'(bus_req), 32'd0);
    check_eq("basic_ack_off", 32'(dev_ack), 32'd0);
    check_eq("basic_src_writes", 32'(clrw_n - cb), ClearEn ? 32'd4 : 32'd0);
    check_eq("basic_slot2", dev_buf[2], ClearEn ? 32'd0 : pat(8'd2));
    check_eq("basic_slot4", dev_buf[4], pat(8'd4));

    // Memory backpressure
    refill();
    wb = wr_n; sb = stall_n;
    stall_addr = 16'h0200; stall_cycles = 3;
    load(8'h10, 16'h0200, 6'd2);
    dreq = 1'b1;
    wait_done("bp", 200);
    dreq = 1'b0;
    stall_cycles = 0;
    check_burst("bp", wb, 2, 16'h0200, 8'h10);
    check_eq("bp_stall_cycles", 32'(stall_n - sb), 32'd3);
    check_eq("bp_stable", 32'(stable_bad), 32'd0);

    // Bus revoke during word 1
    refill();
    wb = wr_n; rb = rd_nogrant;
    load(8'h20, 16'h0300, 6'd5);
    dreq = 1'b1;
    wait_write("rv", 16'h0301, 100);
    gnt_block = 1'b1;
    ack_low = 1'b0; req_low = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!dev_ack) ack_low = 1'b1;
      if (!bus_req) req_low = 1'b1;
    end
    check_eq("rv_hold_cnt", 32'(xfer_count), 32'd2);
    check_eq("rv_gnt_low", 32'(bus_gnt), 32'd0);
    gnt_block = 1'b0;
    check_eq("rv_ack_held", 32'(ack_low), 32'd0);
    check_eq("rv_req_held", 32'(req_low), 32'd0);
    wait_done("rv", 200);
    dreq = 1'b0;
    check_burst("rv", wb, 5, 16'h0300, 8'h20);
    check_eq("rv_no_rd_wo_gnt", 32'(rd_nogrant - rb), 32'd0);

    // Wrap and max length
    refill();
    wb = wr_n;
    load(8'hFE, 16'hFFFE, 6'd32);
    dreq = 1'b1;
    wait_done("wrap", 600);
    dreq = 1'b0;
    check_burst("wrap", wb, 32, 16'hFFFE, 8'hFE);
    check_eq("wrap_addr1", 32'(wr_addr[wb+1]), 32'h0000_FFFF);
    check_eq("wrap_addr2", 32'(wr_addr[wb+2]), 32'h0000_0000);
    check_eq("wrap_data2", wr_data[wb+2], pat(8'h00));
    check_eq("wrap_xfer_count", 32'(xfer_count), 32'd32);

    // Config guards
    refill();
    bb = breq_n;
    load(8'h00, 16'h0400, 6'd0);
    dreq = 1'b1;
    tick(10);
    check_eq("cfg_len0_noreq", 32'(breq_n - bb), 32'd0);
    load(8'h00, 16'h0400, 6'd33);
    tick(10);
    check_eq("cfg_len33_noreq", 32'(breq_n - bb), 32'd0);
    wb = wr_n;
    load(8'h40, 16'h0500, 6'd3);
    tick(4);
    check_eq("cfg_busy", 32'(busy), 32'd1);
    load(8'h00, 16'h0600, 6'd1);
    wait_done("cfg", 200);
    dreq = 1'b0;
    check_burst("cfg", wb, 3, 16'h0500, 8'h40);
    check_eq("cfg_xfer_count", 32'(xfer_count), 32'd3);

    // Reset in the middle of word 2
    refill();
    load(8'h00, 16'h0700, 6'd4);
    dreq = 1'b1;
    wait_write("mr", 16'h0702, 100);
    db = done_n;
    reset = 1'b1;
    tick(1);
    check_reset_vals("mr");
    reset = 1'b0;
    bb = breq_n;
    tick(10);
    check_eq("mr_no_done", 32'(done_n - db), 32'd0);
    check_eq("mr_not_armed", 32'(breq_n - bb), 32'd0);
    dreq = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
